// File: rtl/dense_1_pkg.sv
// Shared constants, trained int8 weights/biases and frame phase type for the dense_1 layer.
// Weight rows are packed little-end first: W[o][i] = W_ROWS[o][8i+7:8i], B[o] = B_ALL[8o+7:8o].
package dense_1_pkg;

   localparam int FIXED = 32;
   localparam int N_IN  = 42;
   localparam int N_OUT = 24;
   localparam int FRAC  = 16;
   localparam int ACC_W = 48;
   localparam int IDX_W = 6;
   localparam int SHIFT = 8;

   localparam logic signed [ACC_W-1:0] SAT_HI = 48'sd65536;
   localparam logic signed [ACC_W-1:0] SAT_LO = -48'sd65536;
   localparam logic [FIXED-1:0] POS_ONE = 32'h0001_0000;
   localparam logic [FIXED-1:0] NEG_ONE = 32'hFFFF_0000;

   typedef enum logic [1:0] {PH_CAPTURE, PH_MAC, PH_OUT} phase_t;

   localparam logic [N_IN*8-1:0] W_ROWS [N_OUT] = '{
      336'h1a2bfe03c7d4_0e9f12f4a5b6_7c08e1d2339a_f00d5e6b47c1_28e9fa11b3d0_4f6e05ac9182_dd3706e8f15a,
      336'h05f3a97e2c10_b8d46e0f3a21_c97d5e08f1b2_6a340dfe8c79_12e5b7a0c34d_f9086e1d2b5c_a3470ef19d28,
      336'he4c1087d2b9f_35a6f0e1c28d_7b4093e6d5a1_f2c80b6e1937_a45d0cf82e16_9b73e0d4a5c2_18f6b9e03d7a,
      336'h7f80017e02fd_c33c5aa5699a_0ff0e11e2dd2_4bb48778965a_a5c3e1d0b2f4_06ff3cc37887_e00e1dd22cc3,
      336'h9a1e6c03f5b8_d0472e9ac1f3_5b8e0d26a7c4_31f9e84b0d6a_c2571a9e3f08_b6d4e2a0917c_4e3f5a6b7c8d,
      336'h0c1d2e3f4a5b_6c7d8e9fa0b1_c2d3e4f50617_28394a5b6c7d_8e9f0a1b2c3d_4e5f60718293_a4b5c6d7e8f9,
      336'hf1e2d3c4b5a6_978869504132_2314f5e6d7c8_b9aa9b8c7d6e_5f4031221304_f5e6d7c8b9aa_0b1c2d3e4f50,
      336'h3a3b3c3d3e3f_c0c1c2c3c4c5_101f2e3d4c5b_6a798897a6b5_c4d3e2f10011_223344556677_8899aabbccdd,
      336'h5e0a91c7d36f_2b84e05ac1f9_7d3e6b0a92c5_f1e84d2b7c06_a9d50e3fb618_c47a2e91d05b_36f8c02e7a1d,
      336'h81c47e2a93d5_06bf18e4a27c_59d30fe6b28a_4c71e5a09d3f_b2e8064ac7d1_9f35a2e07cb4_d8160ea35f29,
      336'h2d9c4fa10e83_b76e15c2da94_08f3e7b65c2a_d1409fe3b57c_6a28e1d0f93b_c5470ae2d186_e93b5f02a7c4,
      336'hc0ffee123456_789abcdef012_3456789abcde_f0fedcba9876_543210fedcba_98765432100f_e1d2c3b4a596,
      336'h4b6a8c2d0e1f_f9e8d7c6b5a4_1324354657f6_e5d4c3b2a190_0a1b2c3d4e5f_6e7d8c9bab0c_1d2e3f405162,
      336'ha7b3c9d1e5f2_08192a3b4c5d_6e7f80f1e2d3_c4b5a6978877_665544332211_00efdecdbcab_9a8978675645,
      336'h13f2e4d6c8ba_9c7e5a3c1e2f_4061728394a5_b6c7d8e9fa0b_1c2d3e4f5061_72839405a6b7_c8d9eafb0c1d,
      336'he61a27b38c49_d05ef16a27b3_8c49d05ef16a_27b38c49d05e_f16a27b38c49_d05ef16a27b3_8c49d05ef16a,
      336'h6f5e4d3c2b1a_0918273645f4_e3d2c1b0a99a_8b7c6d5e4f30_2112f3e4d5c6_b7a8996a5b4c_3d2e1f00f1e2,
      336'h58e3c1a7094b_d2f60e18a35c_7b49e1d0c2f8_a6357e9b1d04_c8f2a5e3610b_9d47c2e8f01a_536b7d8e9fa0,
      336'hb00b1e5ca1ed_fee1900d0ff1_ce0fbadc0de5_a1b2c3d4e5f6_071829304152_637485960718_293a4b5c6d7e,
      336'h9e8d7c6b5a49_38271605f4e3_d2c1b0a9f8e7_d6c5b4a39281_7060504f3e2d_1c0bfae9d8c7_b6a594837261,
      336'h01fe02fd03fc_04fb05fa06f9_07f808f709f6_0af50bf40cf3_0df20ef10ff0_10ef11ee12ed_13ec14eb15ea,
      336'hd7e80f3b2a19_c6a5948372e1_50f4a3b2c1d0_e9f8071625a4_b3c2d1e0f9a8_17263544536a_7b8c9dae0f12,
      336'h2e4c6a8b0d1f_3e5d7c9bb1a2_c3e4f5061728_394a5b6c7d8e_9fa0b1c2d3e4_f5a6b7c8d9ea_fb0c1d2e3f40,
      336'hfa15e8370c2b_4d96a1e5f073_8c2d4b6e9a10_f7c3e85a1d26_b49f0ce7a358_612e8fd4b07c_395ae6c21f84
   };

   localparam logic [N_OUT*8-1:0] B_ALL = 192'hfd12e705c93a_1b60f4a8d27e_08b3ef4596c1_2dfa7e8130f5;

   function automatic logic signed [7:0] w_of(input int o, input int i);
      return W_ROWS[o][8*i +: 8];
   endfunction

   function automatic logic signed [7:0] b_of(input int o);
      return B_ALL[8*o +: 8];
   endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One neuron: bias load, serial 32x8 multiply-accumulate over the input index, hard-tanh output.
// act is combinational from the accumulator; the top registers it at the end of the frame.
module dense_mac_lane
   import dense_1_pkg::*;
#(
   parameter int O = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    mac,
   input  logic [IDX_W-1:0]        idx,
   input  logic signed [FIXED-1:0] x,
   output logic [FIXED-1:0]        act
);

   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   bias_ext;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   y;
   logic signed [7:0]         w;
   logic signed [7:0]         b;
   logic signed [FIXED+7:0]   prod;

   always_comb begin
      w        = w_of(O, int'(idx));
      b        = b_of(O);
      prod     = (FIXED+8)'(x) * (FIXED+8)'(w);
      prod_ext = ACC_W'(prod);
      bias_ext = ACC_W'(b) <<< FRAC;
      // Q16.16 x Q0.8 products carry 24 fraction bits; drop 8 to return to Q16.16
      y        = acc >>> SHIFT;
      if (y > SAT_HI)
         act = POS_ONE;
      else if (y < SAT_LO)
         act = NEG_ONE;
      else
         act = y[FIXED-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (load)
         acc <= bias_ext;
      else if (mac)
         acc <= acc + prod_ext;
   end

endmodule

// File: rtl/dense_1.sv
// Free-running 44-cycle dense layer: capture inputs, 42 parallel MAC steps, register activated outputs.
// No backpressure; out_valid pulses for one cycle each time denseout is refreshed.
module dense_1
   import dense_1_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_IN*FIXED-1:0]   in,
   output logic [N_OUT*FIXED-1:0]  denseout,
   output logic                    out_valid
);

   phase_t                  phase, phase_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic                    load, mac, upd;
   logic signed [FIXED-1:0] in_q [N_IN];
   logic signed [FIXED-1:0] x;
   logic [FIXED-1:0]        act [N_OUT];

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= PH_CAPTURE;
         idx   <= '0;
      end else begin
         phase <= phase_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      phase_nxt = phase;
      idx_nxt   = idx;
      load      = 1'b0;
      mac       = 1'b0;
      upd       = 1'b0;
      case (phase)
         PH_CAPTURE: begin
            load      = 1'b1;
            idx_nxt   = '0;
            phase_nxt = PH_MAC;
         end
         PH_MAC: begin
            mac = 1'b1;
            if (idx == IDX_W'(N_IN-1)) begin
               idx_nxt   = '0;
               phase_nxt = PH_OUT;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         PH_OUT: begin
            upd       = 1'b1;
            phase_nxt = PH_CAPTURE;
         end
         default: phase_nxt = PH_CAPTURE;
      endcase
   end

   // Input snapshot is only taken in the capture cycle, so later changes wait for the next frame
   always_ff @(posedge clk) begin
      if (load) begin
         for (int k = 0; k < N_IN; k++)
            in_q[k] <= in[k*FIXED +: FIXED];
      end
   end

   assign x = in_q[idx];

   for (genvar o = 0; o < N_OUT; o++) begin : g_lane
      dense_mac_lane #(.O(o)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .mac  (mac),
         .idx  (idx),
         .x    (x),
         .act  (act[o])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         denseout  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= upd;
         if (upd) begin
            for (int o = 0; o < N_OUT; o++)
               denseout[o*FIXED +: FIXED] <= act[o];
         end
      end
   end

endmodule

// File: tb/tb_dense_1.sv
// Directed bench for dense_1: expected output frames are queued as each input vector is applied
// and popped when out_valid arrives; timing of the valid pulse is checked against the 44-cycle frame.
module tb_dense_1;
   import dense_1_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_IN*FIXED-1:0]  in;
   logic [N_OUT*FIXED-1:0] denseout;
   logic                   out_valid;

   int errors = 0;
   int checks = 0;
   logic [N_OUT*FIXED-1:0] sb [$];

   dense_1 dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .denseout  (denseout),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [N_OUT*FIXED-1:0] obs,
                          input logic [N_OUT*FIXED-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [N_IN*FIXED-1:0] v, input int o);
      longint acc;
      longint y;
      logic signed [31:0] xw;
      acc = longint'(b_of(o)) * 65536;
      for (int i = 0; i < N_IN; i++) begin
         xw  = v[i*32 +: 32];
         acc = acc + longint'(xw) * longint'(w_of(o, i));
      end
      y = acc >>> 8;
      if (y > 65536)       return 32'h0001_0000;
      else if (y < -65536) return 32'hFFFF_0000;
      else                 return y[31:0];
   endfunction

   function automatic logic [N_OUT*FIXED-1:0] model_vec(input logic [N_IN*FIXED-1:0] v);
      logic [N_OUT*FIXED-1:0] r;
      for (int o = 0; o < N_OUT; o++)
         r[o*32 +: 32] = model(v, o);
      return r;
   endfunction

   function automatic logic [N_IN*FIXED-1:0] rand_vec();
      logic [N_IN*FIXED-1:0] v;
      for (int i = 0; i < N_IN; i++) begin
         int r;
         r = int'($urandom_range(0, 32767)) - 16384;
         v[i*32 +: 32] = r;
      end
      return v;
   endfunction

   task automatic wait_valid(input string tag, input int expn);
      int got;
      got = -1;
      for (int n = 1; n <= expn + 8; n++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            got = n;
            break;
         end
      end
      chk_int({tag, "_latency"}, got, expn);
   endtask

   task automatic check_frame(input string tag);
      logic [N_OUT*FIXED-1:0] e;
      chk_int({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         for (int o = 0; o < N_OUT; o++)
            chk_w($sformatf("%s_o%0d", tag, o), denseout[o*32 +: 32], e[o*32 +: 32]);
      end
   endtask

   initial begin
      logic [N_IN*FIXED-1:0] va, vb, vc;
      int vcount;

      rst = 1'b1;
      in  = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_vec("rst_dout", denseout, '0);
         chk_w("rst_valid", {31'b0, out_valid}, 32'd0);
      end

      // all-zero input: outputs are the biases scaled to Q16.16
      rst = 1'b0;
      sb.push_back(model_vec(in));
      wait_valid("zero", 44);
      check_frame("zero");

      in = '0;
      in[31:0] = 32'h0001_0000;
      sb.push_back(model_vec(in));
      wait_valid("onehot", 44);
      check_frame("onehot");

      for (int i = 0; i < N_IN; i++) in[i*32 +: 32] = 32'h1111_1111;
      sb.push_back(model_vec(in));
      wait_valid("sat", 44);
      check_frame("sat");

      // input changes mid-frame must not disturb the captured vector
      va = rand_vec();
      vb = rand_vec();
      in = va;
      sb.push_back(model_vec(va));
      repeat (21) @(negedge clk);
      in = vb;
      wait_valid("held", 23);
      check_frame("held");
      sb.push_back(model_vec(vb));
      wait_valid("newvec", 44);
      check_frame("newvec");

      // reset in the middle of a frame aborts it
      vc = rand_vec();
      in = vc;
      vcount = 0;
      repeat (31) begin
         @(negedge clk);
         if (out_valid === 1'b1) vcount++;
      end
      chk_int("abort_pre_valid", vcount, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_vec("abort_dout", denseout, '0);
      chk_w("abort_valid", {31'b0, out_valid}, 32'd0);
      rst = 1'b0;
      sb.push_back(model_vec(vc));
      wait_valid("after_rst", 44);
      check_frame("after_rst");

      chk_int("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
